muldiv_ctrl: RTL and testbench

Sequencing controller for the multicycle multiply and divide units. It accepts a MULT/DIV request from the main control FSM, clears and launches the selected unit, and stalls the processor via `busy` until the unit raises its finish flag. It then writes the result into the architectural HI/LO registers. Division by zero is trapped before launch, and a watchdog aborts a unit that never finishes.

---
 rtl/muldiv_ctrl_if.sv | 47 ++++
 rtl/muldiv_ctrl.sv | 131 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Request, status, HI/LO and unit-side signals of the mult/div sequencer.
// slave is the sequencer's view; master is the control FSM plus units.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             timeout_err;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             unit_reset;
  logic             mult_go;
  logic             div_go;
  logic [WIDTH-1:0] unit_x;
  logic [WIDTH-1:0] unit_y;
  logic             mult_fim;
  logic             div_fim;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  modport slave (
    input  req, op, src_a, src_b,
    input  mult_fim, div_fim,
    input  mult_hi, mult_lo, div_hi, div_lo,
    output busy, done, div_zero, timeout_err,
    output hi_q, lo_q,
    output unit_reset, mult_go, div_go,
    output unit_x, unit_y
  );

  modport master (
    output req, op, src_a, src_b,
    output mult_fim, div_fim,
    output mult_hi, mult_lo, div_hi, div_lo,
    input  busy, done, div_zero, timeout_err,
    input  hi_q, lo_q,
    input  unit_reset, mult_go, div_go,
    input  unit_x, unit_y
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for multicycle MULT/DIV units: clear, launch, wait, write HI/LO.
// Divide-by-zero is trapped before launch; a watchdog aborts a hung unit.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CLR, GO, WAIT, WB, DZ, TO
  } state_t;

  state_t           state;
  state_t           nxt;
  logic             op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic fim;
  logic dz_req;
  logic load;
  logic busy;
  logic done;
  logic dz;
  logic to;
  logic ur;
  logic mgo;
  logic dgo;

  assign fim    = op_q ? bus.div_fim : bus.mult_fim;
  assign dz_req = bus.op && (bus.src_b == '0);
  assign load   = (state == IDLE) && bus.req && !dz_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 1'b0;
      cnt   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        op_q <= bus.op;
        x_q  <= bus.src_a;
        y_q  <= bus.src_b;
      end
      if (state == GO) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WB) begin
        hi <= op_q ? bus.div_hi : bus.mult_hi;
        lo <= op_q ? bus.div_lo : bus.mult_lo;
      end
    end
  end

  // cnt holds completed WAIT cycles, so TIMEOUT-1 marks the last one
  always_comb begin
    nxt  = state;
    busy = 1'b1;
    done = 1'b0;
    dz   = 1'b0;
    to   = 1'b0;
    ur   = 1'b0;
    mgo  = 1'b0;
    dgo  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.req) begin
          nxt = dz_req ? DZ : CLR;
        end
      end
      CLR: begin
        ur  = 1'b1;
        nxt = GO;
      end
      GO: begin
        mgo = !op_q;
        dgo = op_q;
        nxt = WAIT;
      end
      WAIT: begin
        if (fim) begin
          nxt = WB;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          nxt = TO;
        end
      end
      WB: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      DZ: begin
        dz  = 1'b1;
        nxt = IDLE;
      end
      TO: begin
        to  = 1'b1;
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_zero    = dz;
  assign bus.timeout_err = to;
  assign bus.unit_reset  = ur;
  assign bus.mult_go     = mgo;
  assign bus.div_go      = dgo;
  assign bus.hi_q        = hi;
  assign bus.lo_q        = lo;
  assign bus.unit_x      = x_q;
  assign bus.unit_y      = y_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: stub units, elapsed-time reference model,
// per-cycle output compare plus literal timing/result checks.
module tb_muldiv_ctrl;
  localparam int W   = 32;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(W)) bus();

  muldiv_ctrl #(
    .WIDTH(W),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // stub units
  int         lat_m    = 0;
  int         lat_d    = 0;
  bit         d_stuck  = 1'b0;
  bit         mf_force = 1'b0;
  logic       mrun     = 1'b0;
  logic       drun     = 1'b0;
  int         mcnt     = 0;
  int         dcnt     = 0;
  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;
  logic [W-1:0] dh = '0;
  logic [W-1:0] dl = '0;

  function automatic logic [63:0] smul(logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [63:0] sdiv(logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    q  = (b == 0) ? 32'sd0 : sa / sb;
    r  = (b == 0) ? 32'sd0 : sa % sb;
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (bus.unit_reset) begin
      mrun <= 1'b0;
      drun <= 1'b0;
    end
    if (bus.mult_go) begin
      mrun     <= 1'b1;
      mcnt     <= lat_m;
      {mh, ml} <= smul(bus.unit_x, bus.unit_y);
    end else if (mrun && mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
    if (bus.div_go) begin
      drun     <= 1'b1;
      dcnt     <= lat_d;
      {dh, dl} <= sdiv(bus.unit_x, bus.unit_y);
    end else if (drun && dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end

  assign bus.mult_fim = (mrun && mcnt == 0) || mf_force;
  assign bus.div_fim  = drun && dcnt == 0 && !d_stuck;
  assign bus.mult_hi  = mh;
  assign bus.mult_lo  = ml;
  assign bus.div_hi   = dh;
  assign bus.div_lo   = dl;

  // reference model: t = cycles since accept (0 = none in flight),
  // fin = terminal cycle kind (1 done, 2 div_zero, 3 timeout)
  int           m_t   = 0;
  int           m_fin = 0;
  logic         m_op  = 1'b0;
  logic [W-1:0] m_x   = '0;
  logic [W-1:0] m_y   = '0;
  logic [W-1:0] m_hi  = '0;
  logic [W-1:0] m_lo  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t   <= 0;
      m_fin <= 0;
      m_op  <= 1'b0;
      m_x   <= '0;
      m_y   <= '0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (m_fin != 0) begin
      if (m_fin == 1) begin
        m_hi <= m_op ? bus.div_hi : bus.mult_hi;
        m_lo <= m_op ? bus.div_lo : bus.mult_lo;
      end
      m_fin <= 0;
      m_t   <= 0;
    end else if (m_t == 0) begin
      if (bus.req) begin
        if (bus.op && bus.src_b == 0) begin
          m_fin <= 2;
        end else begin
          m_t  <= 1;
          m_op <= bus.op;
          m_x  <= bus.src_a;
          m_y  <= bus.src_b;
        end
      end
    end else if (m_t < 3) begin
      m_t <= m_t + 1;
    end else if (m_op ? bus.div_fim : bus.mult_fim) begin
      m_fin <= 1;
      m_t   <= 0;
    end else if (m_t - 2 == TMO) begin
      m_fin <= 3;
      m_t   <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic [198:0] exp_v;
  logic [198:0] act_v;

  always_comb begin
    exp_v = {m_t != 0 || m_fin != 0, m_fin == 1, m_fin == 2, m_fin == 3,
             m_t == 1, m_t == 2 && !m_op, m_t == 2 && m_op,
             m_hi, m_lo, m_x, m_y, 32'd0};
    act_v = {bus.busy, bus.done, bus.div_zero, bus.timeout_err,
             bus.unit_reset, bus.mult_go, bus.div_go,
             bus.hi_q, bus.lo_q, bus.unit_x, bus.unit_y, 32'd0};
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks = checks + 1;
      if (act_v !== exp_v) begin
        failures = failures + 1;
        $display("FAIL cycle_cmp cyc=%0d got=%h exp=%h", cyc, act_v, exp_v);
      end
    end
  end

  // event monitor
  int n_done = 0;
  int n_to   = 0;
  int n_ur   = 0;
  int n_mgo  = 0;
  int n_dgo  = 0;
  int mgo_at = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done)        n_done = n_done + 1;
      if (bus.timeout_err) n_to   = n_to + 1;
      if (bus.unit_reset)  n_ur   = n_ur + 1;
      if (bus.div_go)      n_dgo  = n_dgo + 1;
      if (bus.mult_go) begin
        n_mgo  = n_mgo + 1;
        mgo_at = cyc - acc + 1;
      end
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  task automatic issue(bit o, logic [W-1:0] a, logic [W-1:0] b);
    bus.req   = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    acc     = cyc;
    bus.req = 1'b0;
  endtask

  // which: 0 done, 1 div_zero, 2 timeout_err; at = cycle number after accept
  task automatic wait_for(int which, int maxc, output int at);
    int  i;
    bit  hit;
    at  = -1;
    hit = 1'b0;
    i   = 0;
    while (!hit && i < maxc) begin
      @(negedge clk);
      if ((which == 0 && bus.done) || (which == 1 && bus.div_zero) ||
          (which == 2 && bus.timeout_err)) begin
        hit = 1'b1;
        at  = cyc - acc + 1;
      end
      i++;
    end
    if (!hit) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL wait_pulse kind=%0d got=none exp=pulse within %0d",
               which, maxc);
    end
  endtask

  int at;
  int d0;
  int d1;
  int d2;

  initial begin
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.op    = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({bus.busy, bus.done, bus.div_zero, bus.timeout_err,
                        bus.unit_reset, bus.mult_go, bus.div_go}), 64'd0);
    chk("rst_hilo", {bus.hi_q, bus.lo_q}, 64'd0);
    chk("rst_xy", {bus.unit_x, bus.unit_y}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // MULT 7 * -3, unit latency 32
    lat_m = 32;
    d0    = n_dgo;
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_for(0, 60, at);
    chk("mult_done_cyc", 64'(at), 64'd36);
    chk("mult_go_cyc", 64'(mgo_at), 64'd2);
    chk("mult_no_divgo", 64'(n_dgo - d0), 64'd0);
    @(negedge clk);
    chk("mult_hilo", {bus.hi_q, bus.lo_q}, 64'hFFFF_FFFF_FFFF_FFEB);

    // MULT 0x80000000 * 2, zero-latency unit
    lat_m = 0;
    issue(1'b0, 32'h8000_0000, 32'd2);
    wait_for(0, 20, at);
    chk("mult0_done_cyc", 64'(at), 64'd4);
    @(negedge clk);
    chk("mult0_hilo", {bus.hi_q, bus.lo_q}, 64'hFFFF_FFFF_0000_0000);

    // DIV by zero
    d0 = n_ur;
    d1 = n_mgo + n_dgo;
    issue(1'b1, 32'd100, 32'd0);
    @(negedge clk);
    chk("dz_cyc1", 64'({bus.busy, bus.div_zero}), 64'd3);
    @(negedge clk);
    chk("dz_cyc2_busy", 64'(bus.busy), 64'd0);
    chk("dz_no_unit", 64'((n_ur - d0) + (n_mgo + n_dgo - d1)), 64'd0);
    chk("dz_hilo", {bus.hi_q, bus.lo_q}, 64'hFFFF_FFFF_0000_0000);

    // watchdog with stuck divider, then an immediate follow-up DIV
    d_stuck = 1'b1;
    lat_d   = 3;
    issue(1'b1, 32'd100, 32'd7);
    wait_for(2, 80, at);
    chk("wdog_cyc", 64'(at), 64'(TMO + 3));
    chk("wdog_hilo", {bus.hi_q, bus.lo_q}, 64'hFFFF_FFFF_0000_0000);
    d_stuck   = 1'b0;
    lat_d     = 5;
    bus.req   = 1'b1;
    bus.op    = 1'b1;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    acc     = cyc;
    bus.req = 1'b0;
    @(negedge clk);
    chk("wdog_next_accept", 64'({bus.busy, bus.unit_reset}), 64'd3);
    wait_for(0, 40, at);
    chk("div_done_cyc", 64'(at), 64'd9);
    @(negedge clk);
    chk("div_hilo", {bus.hi_q, bus.lo_q}, {32'd2, 32'd14});

    // mult_fim forced high during a DIV
    lat_d = 10;
    issue(1'b1, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    mf_force = 1'b1;
    wait_for(0, 40, at);
    chk("wrong_fim_cyc", 64'(at), 64'd14);
    mf_force = 1'b0;
    @(negedge clk);

    // fim on the final WAIT cycle wins
    lat_d = TMO - 1;
    d0    = n_to;
    issue(1'b1, 32'd100, 32'd7);
    wait_for(0, 80, at);
    chk("fim_last_wait_cyc", 64'(at), 64'(TMO + 3));
    chk("fim_last_wait_no_to", 64'(n_to - d0), 64'd0);
    @(negedge clk);

    // fim one cycle too late: timeout
    lat_d = TMO;
    d0    = n_done;
    issue(1'b1, 32'd100, 32'd7);
    wait_for(2, 80, at);
    chk("fim_late_to_cyc", 64'(at), 64'(TMO + 3));
    #1;
    chk("fim_late_no_done", 64'(n_done - d0), 64'd0);
    @(negedge clk);

    // req pulsed while busy is ignored
    lat_d = 8;
    d2    = n_done;
    issue(1'b1, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.req   = 1'b1;
    bus.op    = 1'b0;
    bus.src_a = 32'd1;
    bus.src_b = 32'd2;
    @(negedge clk);
    bus.req = 1'b0;
    chk("busy_req_xy", {bus.unit_x, bus.unit_y}, {32'd100, 32'd7});
    wait_for(0, 40, at);
    chk("busy_req_done_cyc", 64'(at), 64'd12);
    repeat (10) @(negedge clk);
    #1;
    chk("busy_req_one_done", 64'(n_done - d2), 64'd1);
    @(negedge clk);

    // asynchronous reset in WAIT cycle 10, then a fresh DIV
    lat_d = 20;
    issue(1'b1, 32'd100, 32'd7);
    repeat (12) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ctl", 64'({bus.busy, bus.done, bus.div_zero, bus.timeout_err,
                         bus.unit_reset, bus.mult_go, bus.div_go}), 64'd0);
    chk("arst_hilo", {bus.hi_q, bus.lo_q}, 64'd0);
    chk("arst_xy", {bus.unit_x, bus.unit_y}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    lat_d = 5;
    issue(1'b1, 32'd100, 32'd7);
    wait_for(0, 40, at);
    chk("arst_div_done_cyc", 64'(at), 64'd9);
    @(negedge clk);
    chk("arst_div_hilo", {bus.hi_q, bus.lo_q}, {32'd2, 32'd14});

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
